coin_bank: RTL

Coin-side front end of the vending machine: it accepts coin pulses, accumulates credit, and drives the 10-bit credit bus into the beverage dispenser's money input. When the dispenser issues a beverage pulse, it captures the dispenser's change output and pays it back as a timed sequence of single-coin eject pulses. A refund request pays out the whole credit the same way. All amounts are in cents.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/coin_bank_if.sv | 37 +++
 rtl/coin_picker.sv | 34 +++
 rtl/coin_bank.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: money type, coin values, beverage prices and the coin-bank
// state encoding shared by the vending-machine blocks.
package vend_pkg;

    // All amounts are cents on a 10-bit bus.
    typedef logic [9:0] money_t;

    // Coin values.
    localparam money_t NICKEL_C  = 10'd5;
    localparam money_t DIME_C    = 10'd10;
    localparam money_t QUARTER_C = 10'd25;
    localparam money_t DOLLAR_C  = 10'd100;

    // Beverage prices charged by the dispenser.
    localparam money_t COFFEE_C  = 10'd65;
    localparam money_t TEA_C     = 10'd55;
    localparam money_t COCOA_C   = 10'd80;
    localparam money_t SOUP_C    = 10'd95;

    // Coin bank sequencing.
    typedef enum logic {
        IDLE,
        PAYOUT
    } bank_state_t;

    // One-hot coin select, largest coin in the top bit.
    typedef struct packed {
        logic dollar;
        logic quarter;
        logic dime;
        logic nickel;
    } coin_sel_t;

endpackage

// File: rtl/coin_bank_if.sv
// coin_bank_if: coin, refund and dispenser handshake signals of the coin bank.
// The master side is the machine front panel / dispenser, the slave side is
// the coin bank itself.
interface coin_bank_if;
    import vend_pkg::*;

    logic   coin_nickel;
    logic   coin_dime;
    logic   coin_quarter;
    logic   coin_dollar;
    logic   refund;
    logic   bev_done;
    money_t change_in;

    money_t credit;
    logic   coin_reject;
    logic   eject_nickel;
    logic   eject_dime;
    logic   eject_quarter;
    logic   eject_dollar;
    logic   busy;

    modport master (
        output coin_nickel, coin_dime, coin_quarter, coin_dollar,
        output refund, bev_done, change_in,
        input  credit, coin_reject,
        input  eject_nickel, eject_dime, eject_quarter, eject_dollar, busy
    );

    modport slave (
        input  coin_nickel, coin_dime, coin_quarter, coin_dollar,
        input  refund, bev_done, change_in,
        output credit, coin_reject,
        output eject_nickel, eject_dime, eject_quarter, eject_dollar, busy
    );

endinterface

// File: rtl/coin_picker.sv
// coin_picker: combinational greedy coin choice for change payout.
// Build option COIN_DOLLAR_EN allows the dollar coin as the largest choice;
// without it quarters are the largest coin paid out.
module coin_picker
    import vend_pkg::*;
(
    input  money_t    remaining,
    output coin_sel_t sel,
    output money_t    value
);

    // Pick the largest coin that still fits into the remaining amount.
    always_comb begin
        sel   = '0;
        value = '0;
`ifdef COIN_DOLLAR_EN
        if (remaining >= DOLLAR_C) begin
            sel.dollar = 1'b1;
            value      = DOLLAR_C;
        end else
`endif
        if (remaining >= QUARTER_C) begin
            sel.quarter = 1'b1;
            value       = QUARTER_C;
        end else if (remaining >= DIME_C) begin
            sel.dime = 1'b1;
            value    = DIME_C;
        end else if (remaining >= NICKEL_C) begin
            sel.nickel = 1'b1;
            value      = NICKEL_C;
        end
    end

endmodule

// File: rtl/coin_bank.sv
// coin_bank: accepts coins, holds credit for the dispenser and pays change or
// refunds back as spaced single-coin eject pulses.
// Build option COIN_DOLLAR_EN accepts the dollar coin and lets the payout use
// it; otherwise dollar coins are always rejected and eject_dollar stays low.
module coin_bank
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 1000,
    parameter int PAYOUT_GAP = 4
)
(
    input  logic        clk,
    input  logic        rst,
    coin_bank_if.slave  bus
);

    localparam int              GAP_W    = $clog2(PAYOUT_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PAYOUT_GAP - 1);
    localparam logic [10:0]     LIMIT    = 11'(MAX_CREDIT);
`ifdef COIN_DOLLAR_EN
    localparam bit DOLLAR_EN = 1'b1;
`else
    localparam bit DOLLAR_EN = 1'b0;
`endif

    bank_state_t      state, state_n;
    money_t           credit_q, credit_n;
    money_t           payout_q, payout_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic             reject_q, reject_n;

    money_t           ins_val;
    logic             ins_hit;
    logic [2:0]       coin_count;
    logic             any_coin;
    logic             extra_coin;
    logic [10:0]      credit_sum;
    logic             over_limit;

    coin_sel_t        pick_sel;
    money_t           pick_val;
    logic             eject_slot;

    coin_picker picker (
        .remaining (payout_q),
        .sel       (pick_sel),
        .value     (pick_val)
    );

    // Decode the inserted coins: highest-priority acceptable coin, how many
    // pulses arrived, and whether accepting it would exceed the credit limit.
    always_comb begin
        ins_val = '0;
        ins_hit = 1'b0;
        if (bus.coin_dollar && DOLLAR_EN) begin
            ins_val = DOLLAR_C;
            ins_hit = 1'b1;
        end else if (bus.coin_quarter) begin
            ins_val = QUARTER_C;
            ins_hit = 1'b1;
        end else if (bus.coin_dime) begin
            ins_val = DIME_C;
            ins_hit = 1'b1;
        end else if (bus.coin_nickel) begin
            ins_val = NICKEL_C;
            ins_hit = 1'b1;
        end
        coin_count = {2'b00, bus.coin_nickel} + {2'b00, bus.coin_dime}
                   + {2'b00, bus.coin_quarter} + {2'b00, bus.coin_dollar};
        any_coin   = (coin_count != 3'd0);
        extra_coin = (coin_count > {2'b00, ins_hit});
        credit_sum = {1'b0, credit_q} + {1'b0, ins_val};
        over_limit = (credit_sum > LIMIT);
    end

    // Next-state logic: coin accounting and payout start in IDLE, greedy
    // ejection with a fixed gap in PAYOUT. The return to IDLE is taken on the
    // last gap cycle so the bank is free again right after the gap ends.
    always_comb begin
        state_n  = state;
        credit_n = credit_q;
        payout_n = payout_q;
        gap_n    = gap_q;
        reject_n = 1'b0;
        case (state)
            IDLE: begin
                gap_n = '0;
                if (bus.bev_done) begin
                    payout_n = bus.change_in;
                    credit_n = '0;
                    reject_n = any_coin;
                    if (bus.change_in >= NICKEL_C) begin
                        state_n = PAYOUT;
                    end
                end else if (bus.refund) begin
                    payout_n = credit_q;
                    credit_n = '0;
                    reject_n = any_coin;
                    if (credit_q >= NICKEL_C) begin
                        state_n = PAYOUT;
                    end
                end else begin
                    reject_n = extra_coin || (ins_hit && over_limit);
                    if (ins_hit && !over_limit) begin
                        credit_n = credit_sum[9:0];
                    end
                end
            end
            PAYOUT: begin
                reject_n = any_coin;
                if (gap_q == '0) begin
                    if (payout_q >= NICKEL_C) begin
                        payout_n = payout_q - pick_val;
                        gap_n    = GAP_LOAD;
                    end else begin
                        payout_n = '0;
                        state_n  = IDLE;
                    end
                end else begin
                    gap_n = gap_q - GAP_W'(1);
                    if ((gap_q == GAP_W'(1)) && (payout_q < NICKEL_C)) begin
                        payout_n = '0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                payout_n = '0;
                gap_n    = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any payout in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit_q <= '0;
            payout_q <= '0;
            gap_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            payout_q <= payout_n;
            gap_q    <= gap_n;
            reject_q <= reject_n;
        end
    end

    assign eject_slot        = (state == PAYOUT) && (gap_q == '0);
    assign bus.eject_nickel  = eject_slot & pick_sel.nickel;
    assign bus.eject_dime    = eject_slot & pick_sel.dime;
    assign bus.eject_quarter = eject_slot & pick_sel.quarter;
    assign bus.eject_dollar  = eject_slot & pick_sel.dollar;
    assign bus.credit        = credit_q;
    assign bus.coin_reject   = reject_q;
    assign bus.busy          = (state == PAYOUT);

endmodule
